// File: rtl/wb_stage_hs_if.sv
// Handshake bundle for wb_stage_hs: retiring-instruction request, per-source
// memory responses and the registered register-file write port.
interface wb_stage_hs_if #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 14,
  parameter int NSRC  = 3,
  parameter int SRC_W = 2
);
  // valid/ready: a request transfers on a rising edge where req_valid and
  // req_ready are both high; the upstream stage holds its fields stable until then.
  logic                 req_valid;
  logic                 req_ready;
  logic [XLEN-1:0]      req_alu;
  logic [PC_W-1:0]      req_pc;
  logic [4:0]           req_rd;
  logic [1:0]           req_wb_sel;
  logic [2:0]           req_load_type;
  logic [SRC_W-1:0]     req_src_sel;
  logic [XLEN-1:0]      req_csr;
  logic [NSRC-1:0]      mem_rsp_valid;
  logic [NSRC*XLEN-1:0] mem_rsp_data;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 busy;

  modport master (
    output req_valid, req_alu, req_pc, req_rd, req_wb_sel, req_load_type,
           req_src_sel, req_csr, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  req_valid, req_alu, req_pc, req_rd, req_wb_sel, req_load_type,
           req_src_sel, req_csr, mem_rsp_valid, mem_rsp_data,
    output req_ready, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/wb_stage_hs.sv
// Writeback stage: one instruction at a time, loads wait for a selected memory
// source. Optional misaligned-load trap enabled by macro WB_MISALIGN_TRAP_EN.
module wb_stage_hs #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 14,
  parameter int NSRC  = 3,
  parameter int SRC_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_stage_hs_if.slave    bus,
  output logic            dbg_wait_o
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
`endif
);
  localparam int OFFW = $clog2(XLEN / 8);
  localparam int NPAD = 1 << SRC_W;
  localparam logic [1:0] WB_CSR = 2'd0, WB_PC4 = 2'd1, WB_MEM = 2'd2;

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [4:0]       rd_q;
  logic [XLEN-1:0]  alu_q;
  logic [2:0]       lt_q;
  logic [SRC_W-1:0] src_q;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic             ready, accept, rsp_hit, sgn, misaligned;
  logic [NPAD-1:0]  rsp_valid_pad;
  logic [XLEN-1:0]  rsp_data, shifted, load_val, result;
  logic [1:0]       size;
  logic [OFFW-1:0]  off, off_eff;
  logic [PC_W-1:0]  pc4;
`ifdef WB_MISALIGN_TRAP_EN
  logic             trap_q, trap_d;
  logic [XLEN-1:0]  maddr_q, maddr_d;
  assign misalign_trap = trap_q;
  assign misalign_addr = maddr_q;
`endif

  assign ready         = (state_q == S_IDLE);
  assign accept        = bus.req_valid && ready;
  assign bus.req_ready = ready;
  assign bus.busy      = (state_q == S_WAIT);
  assign dbg_wait_o    = (state_q == S_WAIT);
  assign bus.rf_we     = we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;

  // Out-of-range source selects land on padding bits that are always zero.
  assign rsp_valid_pad = NPAD'(bus.mem_rsp_valid);
  assign rsp_hit       = rsp_valid_pad[src_q];
  assign pc4           = bus.req_pc + PC_W'(4);

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_q == SRC_W'(i)) rsp_data = bus.mem_rsp_data[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    result = bus.req_alu;
    case (bus.req_wb_sel)
      WB_CSR:  result = bus.req_csr;
      WB_PC4:  result = XLEN'(pc4);
      default: result = bus.req_alu;
    endcase
  end

  // Load alignment: on a 32-bit datapath doubleword encodings collapse to a word.
  always_comb begin
    size = lt_q[1:0];
    if (XLEN == 32 && size == 2'd3) size = 2'd2;
    sgn = !lt_q[2];
    off = alu_q[OFFW-1:0];
    case (size)
      2'd0:    off_eff = off;
      2'd1:    off_eff = off & ~OFFW'(1);
      2'd2:    off_eff = off & ~OFFW'(3);
      default: off_eff = '0;
    endcase
    misaligned = (size == 2'd1 && off[0]) || (size == 2'd2 && off[1:0] != 2'b00);
    shifted    = rsp_data >> {off_eff, 3'b000};
    load_val   = rsp_data;
    case (size)
      2'd0: begin
        if (sgn) load_val = XLEN'($signed(shifted[7:0]));
        else     load_val = XLEN'(shifted[7:0]);
      end
      2'd1: begin
        if (sgn) load_val = XLEN'($signed(shifted[15:0]));
        else     load_val = XLEN'(shifted[15:0]);
      end
      2'd2: begin
        if (sgn) load_val = XLEN'($signed(shifted[31:0]));
        else     load_val = XLEN'(shifted[31:0]);
      end
      default: load_val = rsp_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef WB_MISALIGN_TRAP_EN
    trap_d  = 1'b0;
    maddr_d = maddr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.req_wb_sel == WB_MEM) begin
            state_d = S_WAIT;
          end else if (bus.req_rd != 5'd0) begin
            we_d    = 1'b1;
            waddr_d = bus.req_rd;
            wdata_d = result;
          end
        end
      end
      S_WAIT: begin
        if (rsp_hit) begin
          state_d = S_IDLE;
`ifdef WB_MISALIGN_TRAP_EN
          if (misaligned) begin
            trap_d  = 1'b1;
            maddr_d = alu_q;
          end else
`endif
          if (rd_q != 5'd0) begin
            we_d    = 1'b1;
            waddr_d = rd_q;
            wdata_d = load_val;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      lt_q    <= '0;
      src_q   <= '0;
`ifdef WB_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
      maddr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef WB_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
      maddr_q <= maddr_d;
`endif
      if (accept) begin
        rd_q  <= bus.req_rd;
        alu_q <= bus.req_alu;
        lt_q  <= bus.req_load_type;
        src_q <= bus.req_src_sel;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage_hs.sv
// Directed bench for wb_stage_hs: vector table plus hand sequences for
// back-to-back issue, acceptance-cycle responses and reset during a load.
module tb_wb_stage_hs;
  localparam int XLEN = 32, PC_W = 14, NSRC = 3, SRC_W = 2;
`ifdef WB_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  logic            misalign_trap;
  logic [XLEN-1:0] misalign_addr;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_wait;
  always #5 clk = ~clk;

  wb_stage_hs_if #(.XLEN(XLEN), .PC_W(PC_W), .NSRC(NSRC), .SRC_W(SRC_W)) bus ();

  wb_stage_hs #(.XLEN(XLEN), .PC_W(PC_W), .NSRC(NSRC), .SRC_W(SRC_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_wait_o(dbg_wait)
`ifdef WB_MISALIGN_TRAP_EN
    ,
    .misalign_trap(misalign_trap),
    .misalign_addr(misalign_addr)
`endif
  );

  typedef struct {
    logic [1:0]       wb_sel;
    logic [4:0]       rd;
    logic [XLEN-1:0]  alu;
    logic [PC_W-1:0]  pc;
    logic [XLEN-1:0]  csr;
    logic [2:0]       lt;
    logic [SRC_W-1:0] src;
    logic [XLEN-1:0]  data;
    int               delay;
    bit               exp_we;
    logic [XLEN-1:0]  exp_wdata;
    bit               exp_trap;
  } vec_t;

  vec_t vecs[$];
  logic [XLEN-1:0] exp_q[$];
  logic [4:0]      m_waddr = '0;
  logic [XLEN-1:0] m_wdata = '0;
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic [1:0] ws, logic [4:0] rd, logic [XLEN-1:0] alu,
                              logic [PC_W-1:0] pc, logic [XLEN-1:0] csr, logic [2:0] lt,
                              logic [SRC_W-1:0] src, logic [XLEN-1:0] data, int delay,
                              bit we, logic [XLEN-1:0] wdata, bit trap);
    vec_t v;
    v.wb_sel = ws; v.rd = rd; v.alu = alu; v.pc = pc; v.csr = csr; v.lt = lt;
    v.src = src; v.data = data; v.delay = delay; v.exp_we = we;
    v.exp_wdata = wdata; v.exp_trap = trap;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_port(input string name, input bit exp_we, input bit exp_busy);
    check({name, ".rf_we"}, 64'(bus.rf_we), 64'(exp_we));
    check({name, ".rf_waddr"}, 64'(bus.rf_waddr), 64'(m_waddr));
    check({name, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(m_wdata));
    check({name, ".busy"}, 64'(bus.busy), 64'(exp_busy));
    check({name, ".req_ready"}, 64'(bus.req_ready), 64'(!exp_busy));
  endtask

  task automatic commit(input bit we, input logic [4:0] rd, input logic [XLEN-1:0] wdata);
    if (we) begin
      exp_q.push_back(wdata);
      m_waddr = rd;
      m_wdata = exp_q.pop_front();
    end
  endtask

  task automatic set_req(input vec_t v);
    bus.req_wb_sel = v.wb_sel; bus.req_rd = v.rd; bus.req_alu = v.alu;
    bus.req_pc = v.pc; bus.req_csr = v.csr; bus.req_load_type = v.lt;
    bus.req_src_sel = v.src;
  endtask

  task automatic drive_req(input vec_t v, input string name);
    @(negedge clk);
    check({name, ".pre_ready"}, 64'(bus.req_ready), 64'd1);
    check({name, ".pre_we"}, 64'(bus.rf_we), 64'd0);
    set_req(v);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic respond(input logic [SRC_W-1:0] src, input logic [XLEN-1:0] data, input bit noise_only);
    for (int i = 0; i < NSRC; i++) begin
      bus.mem_rsp_data[i*XLEN +: XLEN] = (i == int'(src)) ? data : XLEN'($urandom);
      bus.mem_rsp_valid[i] = (i == int'(src)) ? !noise_only : 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string name;
    name = $sformatf("vec%0d", idx);
    drive_req(v, name);
    if (v.wb_sel != 2'd2) begin
      commit(v.exp_we, v.rd, v.exp_wdata);
      @(negedge clk);
      check_port(name, v.exp_we, 1'b0);
    end else begin
      for (int d = 0; d < v.delay; d++) begin
        @(negedge clk);
        respond(v.src, v.data, 1'b1);
        check_port({name, ".wait"}, 1'b0, 1'b1);
      end
      @(negedge clk);
      respond(v.src, v.data, 1'b0);
      check({name, ".rsp_busy"}, 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1 bus.mem_rsp_valid = '0;
      commit(v.exp_we, v.rd, v.exp_wdata);
      @(negedge clk);
      check_port(name, v.exp_we, 1'b0);
    end
`ifdef WB_MISALIGN_TRAP_EN
    check({name, ".trap"}, 64'(misalign_trap), 64'(v.exp_trap));
    if (v.exp_trap) check({name, ".trap_addr"}, 64'(misalign_addr), 64'(v.alu));
`endif
  endtask

  initial begin
    vec_t v;
    bus.req_valid = 1'b0; bus.req_alu = '0; bus.req_pc = '0; bus.req_rd = '0;
    bus.req_wb_sel = '0; bus.req_load_type = '0; bus.req_src_sel = '0;
    bus.req_csr = '0; bus.mem_rsp_valid = '0; bus.mem_rsp_data = '0;

    vecs.push_back(mk(2'd3, 5'd5,  32'h1234, 14'h0, 32'h0, 3'b000, 2'd0, 32'h0, 0, 1'b1, 32'h00001234, 1'b0));
    vecs.push_back(mk(2'd1, 5'd1,  32'h0, 14'h3FFC, 32'h0, 3'b000, 2'd0, 32'h0, 0, 1'b1, 32'h00000000, 1'b0));
    vecs.push_back(mk(2'd0, 5'd31, 32'h0, 14'h0, 32'hDEADBEEF, 3'b000, 2'd0, 32'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(2'd1, 5'd2,  32'h0, 14'h0100, 32'h0, 3'b000, 2'd0, 32'h0, 0, 1'b1, 32'h00000104, 1'b0));
    vecs.push_back(mk(2'd3, 5'd0,  32'h55, 14'h0, 32'h0, 3'b000, 2'd0, 32'h0, 0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'd2, 5'd6,  32'h103, 14'h0, 32'h0, 3'b000, 2'd1, 32'h80FF0000, 2, 1'b1, 32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(2'd2, 5'd7,  32'h2, 14'h0, 32'h0, 3'b101, 2'd1, 32'h9ABC0000, 1, 1'b1, 32'h00009ABC, 1'b0));
    vecs.push_back(mk(2'd2, 5'd8,  32'h2, 14'h0, 32'h0, 3'b001, 2'd1, 32'h9ABC0000, 0, 1'b1, 32'hFFFF9ABC, 1'b0));
    vecs.push_back(mk(2'd2, 5'd9,  32'h0, 14'h0, 32'h0, 3'b010, 2'd2, 32'h9ABC0000, 3, 1'b1, 32'h9ABC0000, 1'b0));
    vecs.push_back(mk(2'd2, 5'd10, 32'h1, 14'h0, 32'h0, 3'b100, 2'd0, 32'h0000F100, 1, 1'b1, 32'h000000F1, 1'b0));
    vecs.push_back(mk(2'd2, 5'd11, 32'h0, 14'h0, 32'h0, 3'b000, 2'd1, 32'h1234567F, 0, 1'b1, 32'h0000007F, 1'b0));
    vecs.push_back(mk(2'd2, 5'd12, 32'h0, 14'h0, 32'h0, 3'b011, 2'd1, 32'hCAFEF00D, 1, 1'b1, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(2'd2, 5'd0,  32'h4, 14'h0, 32'h0, 3'b010, 2'd1, 32'h12345678, 1, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(2'd2, 5'd15, 32'h1002, 14'h0, 32'h0, 3'b010, 2'd1, 32'h11223344, 2, !TRAP_EN, 32'h11223344, TRAP_EN));
    vecs.push_back(mk(2'd2, 5'd16, 32'h3, 14'h0, 32'h0, 3'b101, 2'd2, 32'hBEEF0000, 1, !TRAP_EN, 32'h0000BEEF, TRAP_EN));
    vecs.push_back(mk(2'd2, 5'd17, 32'h0, 14'h0, 32'h0, 3'b110, 2'd1, 32'h80000000, 0, 1'b1, 32'h80000000, 1'b0));
    vecs.push_back(mk(2'd2, 5'd18, 32'h0, 14'h0, 32'h0, 3'b111, 2'd0, 32'h87654321, 2, 1'b1, 32'h87654321, 1'b0));

    // Reset values while rst_n is held low
    #12;
    check_port("reset", 1'b0, 1'b0);
    check("reset.dbg", 64'(dbg_wait), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back ALU requests, one per cycle
    v = mk(2'd3, 5'd13, 32'hA, 14'h0, 32'h0, 3'b000, 2'd0, 32'h0, 0, 1'b1, 32'hA, 1'b0);
    @(negedge clk);
    set_req(v);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_rd = 5'd14; bus.req_alu = 32'hB;
    commit(1'b1, 5'd13, 32'hA);
    @(negedge clk);
    check_port("b2b_first", 1'b1, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    commit(1'b1, 5'd14, 32'hB);
    @(negedge clk);
    check_port("b2b_second", 1'b1, 1'b0);

    // A response present in the acceptance cycle must be ignored
    v = mk(2'd2, 5'd4, 32'h0, 14'h0, 32'h0, 3'b010, 2'd1, 32'h0, 0, 1'b1, 32'h0F0F0F0F, 1'b0);
    @(negedge clk);
    set_req(v);
    bus.req_valid = 1'b1;
    respond(2'd1, 32'hAAAA5555, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.mem_rsp_valid = '0;
    @(negedge clk);
    check_port("acc_rsp_wait1", 1'b0, 1'b1);
    @(negedge clk);
    check_port("acc_rsp_wait2", 1'b0, 1'b1);
    respond(2'd1, 32'h0F0F0F0F, 1'b0);
    @(posedge clk);
    #1 bus.mem_rsp_valid = '0;
    commit(1'b1, 5'd4, 32'h0F0F0F0F);
    @(negedge clk);
    check_port("acc_rsp_done", 1'b1, 1'b0);

    // Reset while waiting drops the load
    v = mk(2'd2, 5'd3, 32'h0, 14'h0, 32'h0, 3'b010, 2'd1, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    drive_req(v, "rst_wait");
    @(negedge clk);
    check("rst_wait.busy_before", 64'(bus.busy), 64'd1);
    check("rst_wait.dbg_before", 64'(dbg_wait), 64'd1);
    #2 rst_n = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    #1 check_port("rst_wait.async", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    respond(2'd1, 32'h76543210, 1'b0);
    @(posedge clk);
    #1 bus.mem_rsp_valid = '0;
    @(negedge clk);
    check_port("rst_wait.after", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
